// File: rtl/sr_fifo_mc.sv
// Multi-channel show-ahead FIFO: CHANNELS independent circular queues in one shared storage array,
// with per-channel occupancy status and sticky overflow/underflow flags.
module sr_fifo_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CHANNELS   = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pushEn,
    input  logic [CW-1:0]              pushCh,
    input  logic [DATA_WIDTH-1:0]      pushData,
    input  logic                       popEn,
    input  logic [CW-1:0]              popCh,
    output logic [DATA_WIDTH-1:0]      popData,
    output logic                       popValid,
    output logic [CHANNELS-1:0]        full,
    output logic [CHANNELS-1:0]        empty,
    output logic [CHANNELS*(AW+1)-1:0] count,
    input  logic                       clearErr,
    output logic [CHANNELS-1:0]        overflow,
    output logic [CHANNELS-1:0]        underflow
);

    localparam int NENT = CHANNELS * DEPTH;
    localparam int MAW  = (NENT > 1) ? $clog2(NENT) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [NENT];

    logic [AW-1:0]       rdPtr_q [CHANNELS];
    logic [AW-1:0]       rdPtr_d [CHANNELS];
    logic [AW-1:0]       wrPtr_q [CHANNELS];
    logic [AW-1:0]       wrPtr_d [CHANNELS];
    logic [AW:0]         cnt_q   [CHANNELS];
    logic [AW:0]         cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] overflow_q, overflow_d;
    logic [CHANNELS-1:0] underflow_q, underflow_d;

    logic          pushChOk, popChOk;
    logic [CW-1:0] pushIdx, popIdx;
    logic          popHasData, pushIsFull, sameCh;
    logic          popAccept, pushAccept, ovfEvent, unfEvent;
    logic [MAW-1:0] rdAddr, wrAddr;

    // Out-of-range channel indices are folded onto channel 0 for array access, but never act.
    assign pushChOk = int'(pushCh) < CHANNELS;
    assign popChOk  = int'(popCh) < CHANNELS;
    assign pushIdx  = pushChOk ? pushCh : '0;
    assign popIdx   = popChOk ? popCh : '0;

    assign popHasData = popChOk && (cnt_q[popIdx] != '0);
    assign pushIsFull = cnt_q[pushIdx] == FULL_COUNT;
    assign sameCh     = pushIdx == popIdx;

    // A push into a full channel is still accepted when the same channel is popped this cycle.
    assign popAccept  = popEn && popHasData;
    assign pushAccept = pushEn && pushChOk && (!pushIsFull || (popAccept && sameCh));
    assign ovfEvent   = pushEn && pushChOk && pushIsFull && !(popAccept && sameCh);
    assign unfEvent   = popEn && popChOk && !popHasData;

    assign rdAddr = MAW'({popIdx, rdPtr_q[popIdx]});
    assign wrAddr = MAW'({pushIdx, wrPtr_q[pushIdx]});

    assign popValid = popHasData;
    assign popData  = popHasData ? mem_q[rdAddr] : '0;

    always_comb begin
        overflow_d  = clearErr ? '0 : overflow_q;
        underflow_d = clearErr ? '0 : underflow_q;
        for (int i = 0; i < CHANNELS; i++) begin
            logic inc, dec;
            inc = pushAccept && (pushIdx == CW'(i));
            dec = popAccept && (popIdx == CW'(i));
            rdPtr_d[i] = dec ? rdPtr_q[i] + AW'(1) : rdPtr_q[i];
            wrPtr_d[i] = inc ? wrPtr_q[i] + AW'(1) : wrPtr_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + (AW+1)'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - (AW+1)'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            if (ovfEvent && (pushIdx == CW'(i))) begin
                overflow_d[i] = 1'b1;
            end
            if (unfEvent && (popIdx == CW'(i))) begin
                underflow_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count[i*(AW+1) +: AW+1] = cnt_q[i];
            full[i]  = cnt_q[i] == FULL_COUNT;
            empty[i] = cnt_q[i] == '0;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                rdPtr_q[i] <= '0;
                wrPtr_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            overflow_q  <= '0;
            underflow_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                rdPtr_q[i] <= rdPtr_d[i];
                wrPtr_q[i] <= wrPtr_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; emptiness alone masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && pushAccept) begin
            mem_q[wrAddr] <= pushData;
        end
    end

endmodule

// File: tb/tb_sr_fifo_mc.sv
// Self-checking bench for sr_fifo_mc: directed vector table followed by randomized traffic
// compared against a queue-based reference model.
module tb_sr_fifo_mc;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CH = 2;
    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          pushEn;
    logic [0:0]    pushCh;
    logic [DW-1:0] pushData;
    logic          popEn;
    logic [0:0]    popCh;
    logic [DW-1:0] popData;
    logic          popValid;
    logic [CH-1:0] full;
    logic [CH-1:0] empty;
    logic [CH*(AW+1)-1:0] count;
    logic          clearErr;
    logic [CH-1:0] overflow;
    logic [CH-1:0] underflow;

    int nChecks = 0;
    int nFails  = 0;

    sr_fifo_mc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset),
        .pushEn(pushEn), .pushCh(pushCh), .pushData(pushData),
        .popEn(popEn), .popCh(popCh), .popData(popData), .popValid(popValid),
        .full(full), .empty(empty), .count(count),
        .clearErr(clearErr), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pe, pc;
        logic [31:0] pd;
        logic        oe, oc, ce;
        logic [31:0] expData;
        logic        expValid;
        int          expC0, expC1;
        logic [1:0]  expOvf, expUnf;
    } vecT;

    vecT vecs[$];

    function automatic vecT mkVec(input logic rst, input logic pe, input logic pc,
                                  input logic [31:0] pd, input logic oe, input logic oc,
                                  input logic ce, input logic [31:0] ed, input logic ev,
                                  input int c0, input int c1,
                                  input logic [1:0] ov, input logic [1:0] un);
        vecT v;
        v.rst = rst; v.pe = pe; v.pc = pc; v.pd = pd;
        v.oe = oe; v.oc = oc; v.ce = ce;
        v.expData = ed; v.expValid = ev;
        v.expC0 = c0; v.expC1 = c1; v.expOvf = ov; v.expUnf = un;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic pe, input logic pc,
                                 input logic [31:0] pd, input logic oe, input logic oc,
                                 input logic ce);
        reset = rst; pushEn = pe; pushCh = pc; pushData = pd;
        popEn = oe; popCh = oc; clearErr = ce;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] chCount(input int ch);
        return 32'(count[ch*(AW+1) +: AW+1]);
    endfunction

    task automatic checkState(input string tag, input int c0, input int c1,
                              input logic [1:0] ov, input logic [1:0] un);
        logic [1:0] expFull, expEmpty;
        expFull  = {c1 == DEPTH, c0 == DEPTH};
        expEmpty = {c1 == 0, c0 == 0};
        checkOutput({tag, " count0"}, chCount(0), 32'(c0));
        checkOutput({tag, " count1"}, chCount(1), 32'(c1));
        checkOutput({tag, " full"}, 32'(full), 32'(expFull));
        checkOutput({tag, " empty"}, 32'(empty), 32'(expEmpty));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(ov));
        checkOutput({tag, " underflow"}, 32'(underflow), 32'(un));
    endtask

    // Reference model: one queue per channel plus sticky flag bits.
    logic [31:0] modelQ [CH][$];
    logic [1:0]  modelOvf, modelUnf;

    task automatic modelStep(input logic rst, input logic pe, input logic pc,
                             input logic [31:0] pd, input logic oe, input logic oc,
                             input logic ce);
        int  szPush, szPop;
        logic popOk, pushOk;
        if (rst) begin
            for (int i = 0; i < CH; i++) modelQ[i].delete();
            modelOvf = '0;
            modelUnf = '0;
            return;
        end
        szPush = modelQ[pc].size();
        szPop  = modelQ[oc].size();
        popOk  = oe && (szPop > 0);
        pushOk = pe && ((szPush < DEPTH) || (popOk && (oc == pc)));
        if (ce) begin
            modelOvf = '0;
            modelUnf = '0;
        end
        if (pe && !pushOk) modelOvf[pc] = 1'b1;
        if (oe && !popOk) modelUnf[oc] = 1'b1;
        if (popOk) void'(modelQ[oc].pop_front());
        if (pushOk) modelQ[pc].push_back(pd);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkState("reset", 0, 0, 2'b00, 2'b00);

        //                rst pe pc pd         oe oc ce  expData    v  c0 c1 ovf    unf
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 0, 32'hA1,   0, 0, 0, 32'h0,    0, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 0, 32'hA2,   0, 0, 0, 32'hA1,   1, 2, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 0, 32'hA3,   0, 0, 0, 32'hA1,   1, 3, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 0, 0, 32'hA1,   1, 2, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 0, 0, 32'hA2,   1, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 0, 0, 32'hA3,   1, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 1, 32'h10,   0, 1, 0, 32'h0,    0, 0, 1, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 1, 32'h11,   0, 1, 0, 32'h10,   1, 0, 2, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 1, 32'h12,   0, 1, 0, 32'h10,   1, 0, 3, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 1, 32'h13,   0, 1, 0, 32'h10,   1, 0, 4, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 1, 1, 32'h14,   0, 1, 0, 32'h10,   1, 0, 4, 2'b10, 2'b00));
        vecs.push_back(mkVec(0, 1, 1, 32'h55,   1, 1, 0, 32'h10,   1, 0, 4, 2'b10, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 1, 0, 32'h11,   1, 0, 3, 2'b10, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 1, 0, 32'h12,   1, 0, 2, 2'b10, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 1, 0, 32'h13,   1, 0, 1, 2'b10, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 1, 0, 32'h55,   1, 0, 0, 2'b10, 2'b00));
        vecs.push_back(mkVec(0, 1, 0, 32'h77,   1, 0, 0, 32'h0,    0, 1, 0, 2'b10, 2'b01));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 0, 0, 32'h77,   1, 0, 0, 2'b10, 2'b01));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    0, 0, 1, 32'h0,    0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    1, 0, 1, 32'h0,    0, 0, 0, 2'b00, 2'b01));
        vecs.push_back(mkVec(0, 1, 0, 32'hB0,   0, 0, 0, 32'h0,    0, 1, 0, 2'b00, 2'b01));
        vecs.push_back(mkVec(0, 1, 0, 32'hB1,   0, 0, 0, 32'hB0,   1, 2, 0, 2'b00, 2'b01));
        vecs.push_back(mkVec(0, 1, 1, 32'hC0,   0, 0, 0, 32'hB0,   1, 2, 1, 2'b00, 2'b01));
        vecs.push_back(mkVec(0, 1, 1, 32'hC1,   0, 0, 0, 32'hB0,   1, 2, 2, 2'b00, 2'b01));
        vecs.push_back(mkVec(0, 1, 1, 32'hC2,   0, 0, 0, 32'hB0,   1, 2, 3, 2'b00, 2'b01));
        vecs.push_back(mkVec(1, 1, 0, 32'hDD,   1, 0, 1, 32'hB0,   1, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mkVec(0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 0, 0, 2'b00, 2'b00));

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            applyStimulus(vecs[k].rst, vecs[k].pe, vecs[k].pc, vecs[k].pd,
                          vecs[k].oe, vecs[k].oc, vecs[k].ce);
            #2;
            checkOutput({tag, " popData"}, popData, vecs[k].expData);
            checkOutput({tag, " popValid"}, 32'(popValid), 32'(vecs[k].expValid));
            @(posedge clk);
            #1;
            checkState(tag, vecs[k].expC0, vecs[k].expC1, vecs[k].expOvf, vecs[k].expUnf);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        modelStep(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        for (int n = 0; n < 600; n++) begin
            logic rst, pe, pc, oe, oc, ce;
            logic [31:0] pd, expD;
            string tag;
            tag = $sformatf("rnd%0d", n);
            rst = ($urandom_range(0, 79) == 0);
            pe  = ($urandom_range(0, 99) < 60);
            pc  = 1'($urandom_range(0, 1));
            pd  = $urandom;
            oe  = ($urandom_range(0, 99) < 50);
            oc  = 1'($urandom_range(0, 1));
            ce  = ($urandom_range(0, 15) == 0);
            applyStimulus(rst, pe, pc, pd, oe, oc, ce);
            #2;
            expD = (modelQ[oc].size() > 0) ? modelQ[oc][0] : 32'h0;
            checkOutput({tag, " popData"}, popData, expD);
            checkOutput({tag, " popValid"}, 32'(popValid), 32'(modelQ[oc].size() > 0));
            modelStep(rst, pe, pc, pd, oe, oc, ce);
            @(posedge clk);
            #1;
            checkState(tag, modelQ[0].size(), modelQ[1].size(), modelOvf, modelUnf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
